// File: rtl/bus_pkg.sv
// Shared definitions for the two-port memory bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/payload until gnt; memory stalls with mem_ready=0.
// Modports: master = arbiter view (drives gnt/ack/err/data and mem_*),
//           slave  = environment view (requesters and memory).
interface mem_bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              r0_req, r0_rw, r0_lock, r0_gnt, r0_ack, r0_err;
    logic [ADDR_W-1:0] r0_address;
    logic [DATA_W-1:0] r0_datao, r0_data;
    logic              r1_req, r1_rw, r1_lock, r1_gnt, r1_ack, r1_err;
    logic [ADDR_W-1:0] r1_address;
    logic [DATA_W-1:0] r1_datao, r1_data;
    logic              mem_en, mem_rw, mem_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datao, mem_data;

    modport master (
        input  r0_req, r0_rw, r0_lock, r0_address, r0_datao,
        input  r1_req, r1_rw, r1_lock, r1_address, r1_datao,
        output r0_gnt, r0_ack, r0_err, r0_data,
        output r1_gnt, r1_ack, r1_err, r1_data,
        output mem_en, mem_rw, mem_address, mem_datao,
        input  mem_data, mem_ready
    );

    modport slave (
        output r0_req, r0_rw, r0_lock, r0_address, r0_datao,
        output r1_req, r1_rw, r1_lock, r1_address, r1_datao,
        input  r0_gnt, r0_ack, r0_err, r0_data,
        input  r1_gnt, r1_ack, r1_err, r1_data,
        input  mem_en, mem_rw, mem_address, mem_datao,
        output mem_data, mem_ready
    );
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Two-way round-robin winner selection with a bounded lock override.
// Latency: combinational.
// Backpressure: none; valid only says someone is requesting.
// Ports: req[1:0], prio, last_owner, last_lock, run_cnt_ok -> winner, valid.
module arb_pick
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       last_owner,
    input  logic       last_lock,
    input  logic       run_cnt_ok,
    output logic       winner,
    output logic       valid
);
    always_comb begin
        valid  = |req;
        winner = prio;
        // A locked owner keeps the bus while under its run budget, or at any
        // time the other side is not asking for it.
        if (last_lock && req[last_owner] && (run_cnt_ok || !req[~last_owner])) begin
            winner = last_owner;
        end else if (req == 2'b01) begin
            winner = REQ_CPU;
        end else if (req == 2'b10) begin
            winner = REQ_DMA;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between CPU (r0) and DMA (r1), one transaction per grant.
// Latency: gnt the cycle after req seen in IDLE; ack the cycle after mem_ready (or timeout).
// Backpressure: memory stalls via mem_ready; requests are only considered in IDLE.
// Ports: clock/reset (sync, active-high) and bus (master modport of mem_bus_arbiter_if).
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 8,
    parameter int TIMEOUT  = 16
) (
    input logic              clock,
    input logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam int RC_W = $clog2(MAX_HOLD + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              prio_q;
    logic [RC_W-1:0]   run_cnt_q;
    logic [WD_W-1:0]   wd_q;
    logic              last_vld_q, last_owner_q, last_lock_q;
    logic              owner_q, rw_q;
    logic [1:0]        gnt_q, ack_q, err_q;
    logic [DATA_W-1:0] rdata_q [2];
    logic              mem_en_q, mem_rw_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_datao_q;

    logic              pick_win, pick_vld;
    logic              do_grant, do_done, done_err;
    logic              sel_rw, sel_lock;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_datao;

    arb_pick u_pick (
        .req        ({bus.r1_req, bus.r0_req}),
        .prio       (prio_q),
        .last_owner (last_owner_q),
        .last_lock  (last_lock_q & last_vld_q),
        .run_cnt_ok (run_cnt_q < RC_W'(MAX_HOLD)),
        .winner     (pick_win),
        .valid      (pick_vld)
    );

    assign sel_rw      = pick_win ? bus.r1_rw      : bus.r0_rw;
    assign sel_lock    = pick_win ? bus.r1_lock    : bus.r0_lock;
    assign sel_address = pick_win ? bus.r1_address : bus.r0_address;
    assign sel_datao   = pick_win ? bus.r1_datao   : bus.r0_datao;

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d  = ACCESS;
                    do_grant = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    do_done = 1'b1;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d  = RESP;
                    do_done  = 1'b1;
                    done_err = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            prio_q        <= REQ_CPU;
            run_cnt_q     <= '0;
            wd_q          <= '0;
            last_vld_q    <= 1'b0;
            last_owner_q  <= REQ_CPU;
            last_lock_q   <= 1'b0;
            owner_q       <= REQ_CPU;
            rw_q          <= 1'b0;
            gnt_q         <= '0;
            ack_q         <= '0;
            err_q         <= '0;
            rdata_q[0]    <= '0;
            rdata_q[1]    <= '0;
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_address_q <= '0;
            mem_datao_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;

            if (do_grant) begin
                owner_q       <= pick_win;
                rw_q          <= sel_rw;
                gnt_q[pick_win] <= 1'b1;
                prio_q        <= ~pick_win;
                // Run length of back-to-back grants to the same owner.
                if (last_vld_q && last_owner_q == pick_win) begin
                    if (run_cnt_q != RC_W'(MAX_HOLD))
                        run_cnt_q <= run_cnt_q + RC_W'(1);
                end else begin
                    run_cnt_q <= RC_W'(1);
                end
                last_vld_q    <= 1'b1;
                last_owner_q  <= pick_win;
                last_lock_q   <= sel_lock;
                wd_q          <= '0;
                mem_en_q      <= 1'b1;
                mem_rw_q      <= sel_rw;
                mem_address_q <= sel_address;
                mem_datao_q   <= sel_datao;
            end

            if (state_q == ACCESS && !do_done)
                wd_q <= wd_q + WD_W'(1);

            if (do_done) begin
                wd_q           <= '0;
                ack_q[owner_q] <= 1'b1;
                err_q[owner_q] <= done_err;
                if (!done_err && !rw_q)
                    rdata_q[owner_q] <= bus.mem_data;
                mem_en_q      <= 1'b0;
                mem_rw_q      <= 1'b0;
                mem_address_q <= '0;
                mem_datao_q   <= '0;
            end
        end
    end

    assign bus.r0_gnt      = gnt_q[0];
    assign bus.r1_gnt      = gnt_q[1];
    assign bus.r0_ack      = ack_q[0];
    assign bus.r1_ack      = ack_q[1];
    assign bus.r0_err      = err_q[0];
    assign bus.r1_err      = err_q[1];
    assign bus.r0_data     = rdata_q[0];
    assign bus.r1_data     = rdata_q[1];
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_datao   = mem_datao_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset state, read, waited write,
// round-robin contention, lock bound, timeout and reset during ACCESS.
module tb_mem_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_HOLD(8), .TIMEOUT(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.r0_req = 0; bus.r0_rw = 0; bus.r0_lock = 0; bus.r0_address = 0; bus.r0_datao = 0;
        bus.r1_req = 0; bus.r1_rw = 0; bus.r1_lock = 0; bus.r1_address = 0; bus.r1_datao = 0;
        bus.mem_ready = 0; bus.mem_data = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Wait (bounded) for the next grant; checks who got it and returns the gap in cycles.
    task automatic wait_gnt(input string tag, input logic exp_who, output int gap);
        logic seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            gap++;
            if (bus.r0_gnt || bus.r1_gnt) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_one_hot"}, 32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
        chk({tag, "_who"}, 32'(bus.r1_gnt), 32'(exp_who));
    endtask

    initial begin
        int gap;
        int cnt;
        int acks;
        logic exp_who;

        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_mem_en",   32'(bus.mem_en), 32'd0);
        chk("rst_mem_addr", bus.mem_address, 32'd0);
        chk("rst_gnt",      32'({bus.r1_gnt, bus.r0_gnt}), 32'd0);
        chk("rst_ack",      32'({bus.r1_ack, bus.r0_ack}), 32'd0);
        chk("rst_r0_data",  bus.r0_data, 32'd0);
        chk("rst_r1_data",  bus.r1_data, 32'd0);

        // Single zero-wait read
        bus.r0_req = 1; bus.r0_rw = 0; bus.r0_address = 32'h10;
        bus.mem_ready = 1; bus.mem_data = 32'hDEADBEEF;
        step();
        chk("rd_gnt",    32'(bus.r0_gnt), 32'd1);
        chk("rd_mem_en", 32'(bus.mem_en), 32'd1);
        chk("rd_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("rd_addr",   bus.mem_address, 32'h10);
        bus.r0_req = 0;
        step();
        chk("rd_ack",    32'(bus.r0_ack), 32'd1);
        chk("rd_err",    32'(bus.r0_err), 32'd0);
        chk("rd_data",   bus.r0_data, 32'hDEADBEEF);
        chk("rd_en_off", 32'(bus.mem_en), 32'd0);
        step();
        chk("rd_ack_pulse", 32'(bus.r0_ack), 32'd0);

        // Write with three wait states
        bus.mem_ready = 0; bus.mem_data = 32'hCAFEF00D;
        bus.r1_req = 1; bus.r1_rw = 1; bus.r1_address = 32'h20; bus.r1_datao = 32'h1234;
        step();
        chk("wr_gnt", 32'(bus.r1_gnt), 32'd1);
        bus.r1_req = 0; bus.r1_address = 32'hFFFF; bus.r1_datao = 32'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk("wr_en",    32'(bus.mem_en), 32'd1);
            chk("wr_rw",    32'(bus.mem_rw), 32'd1);
            chk("wr_addr",  bus.mem_address, 32'h20);
            chk("wr_datao", bus.mem_datao, 32'h1234);
            chk("wr_no_ack", 32'(bus.r1_ack), 32'd0);
            if (i == 3) bus.mem_ready = 1;
            step();
        end
        chk("wr_ack",    32'(bus.r1_ack), 32'd1);
        chk("wr_err",    32'(bus.r1_err), 32'd0);
        chk("wr_data",   bus.r1_data, 32'd0);
        chk("wr_en_off", 32'(bus.mem_en), 32'd0);
        idle_inputs();
        step();

        // Contention without lock: strict alternation, 3-cycle spacing
        do_reset();
        bus.mem_ready = 1; bus.mem_data = 32'h5555AAAA;
        bus.r0_req = 1; bus.r1_req = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt("rr", 1'(i % 2), gap);
            if (i > 0) chk("rr_gap", 32'(gap), 32'd3);
        end

        // Lock: r0 gets exactly 8 grants against a competing r1, then r1
        do_reset();
        bus.r0_lock = 1; bus.r0_req = 1; bus.r1_req = 1;
        for (int i = 0; i < 9; i++) begin
            exp_who = (i < 8) ? 1'b0 : 1'b1;
            wait_gnt("lock", exp_who, gap);
        end
        bus.r1_req = 0;
        // r1 idle: r0 keeps the bus well past the hold budget
        for (int i = 0; i < 10; i++) wait_gnt("lock_solo", 1'b0, gap);
        bus.r0_req = 0; bus.r0_lock = 0;
        for (int i = 0; i < 4; i++) step();
        chk("lock_r0_data", bus.r0_data, 32'h5555AAAA);

        // Timeout: 16 ACCESS cycles then error ack, data untouched
        bus.mem_ready = 0; bus.mem_data = 32'h0BADF00D;
        bus.r0_req = 1; bus.r0_rw = 0; bus.r0_address = 32'h40;
        wait_gnt("to", 1'b0, gap);
        bus.r0_req = 0;
        cnt = 0;
        while (bus.mem_en && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_cycles", 32'(cnt), 32'd16);
        chk("to_ack",    32'(bus.r0_ack), 32'd1);
        chk("to_err",    32'(bus.r0_err), 32'd1);
        chk("to_data",   bus.r0_data, 32'h5555AAAA);
        step();
        // Following request is served normally
        bus.mem_ready = 1; bus.mem_data = 32'h600DCAFE;
        bus.r0_req = 1;
        wait_gnt("post_to", 1'b0, gap);
        bus.r0_req = 0;
        step();
        chk("post_to_ack",  32'(bus.r0_ack), 32'd1);
        chk("post_to_err",  32'(bus.r0_err), 32'd0);
        chk("post_to_data", bus.r0_data, 32'h600DCAFE);
        step();

        // Reset in the 2nd ACCESS cycle: bus released, no ack, prio back to r0
        bus.mem_ready = 0;
        bus.r0_req = 1;
        wait_gnt("mid", 1'b0, gap);
        bus.r0_req = 0;
        step();
        chk("mid_en_before", 32'(bus.mem_en), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_en_off", 32'(bus.mem_en), 32'd0);
        bus.mem_ready = 1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.r0_ack || bus.r1_ack) acks++;
            step();
        end
        chk("mid_no_ack", 32'(acks), 32'd0);
        bus.r0_req = 1; bus.r1_req = 1;
        wait_gnt("mid_prio", 1'b0, gap);
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
